// File: rtl/linear_array_run_controller_pkg.sv
// Shared definitions for the linear array run controller and the array top level.
// Holds the controller state encoding and the lane-count derivations.
// Pure declarations; no logic, no latency, no backpressure.
package linear_array_run_controller_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE,
    S_ABORT = ST_ABORT
  } state_t;

  // Top (weight) lanes: one per PE.
  function automatic int NT(input int pe_i, input int pe_j);
    return pe_i * pe_j;
  endfunction

  // Left (data) lanes: one per j-row per batch.
  function automatic int NL(input int pe_j, input int batch);
    return pe_j * batch;
  endfunction

  // Down (partial-sum) lanes: one per i-column per batch.
  function automatic int ND(input int pe_i, input int batch);
    return pe_i * batch;
  endfunction

endpackage

// File: rtl/lane_beat_gate.sv
// One input lane gate: opens the valid/ready pair while running, counts beats, marks tlast.
// Latency: combinational pass-through of valid/ready; counter and done flag update on the edge.
// Backpressure: ready mirrors array ready while enabled; enable depends on registers only.
module lane_beat_gate #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 up_tvalid,
  output logic                 up_tready,
  output logic                 arr_tvalid,
  input  logic                 arr_tready,
  output logic                 arr_tlast,
  output logic                 in_done
);

  localparam logic [LEN_WIDTH-1:0] L_ONE = LEN_WIDTH'(1);

  logic [LEN_WIDTH-1:0] cnt;
  logic                 en;
  logic                 hs;
  logic                 at_last;

  // Gating and final-beat marking from registered state only.
  always_comb begin
    en         = run & ~in_done;
    at_last    = (cnt == (len - L_ONE));
    arr_tvalid = up_tvalid & en;
    up_tready  = arr_tready & en;
    arr_tlast  = en & at_last;
    hs         = arr_tvalid & arr_tready;
  end

  // Beat counter; the handshake on the final beat closes the lane for the rest of the run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      in_done <= 1'b0;
    end else if (hs) begin
      cnt <= cnt + L_ONE;
      if (at_last) in_done <= 1'b1;
    end
  end

endmodule

// File: rtl/linear_array_run_controller.sv
// Run sequencer: gates top/left lane handshakes, counts output tlasts, repeats for cfg_runs.
// Latency: lanes open the cycle after cfg accept; done pulses the cycle after the last output tlast.
// Backpressure: cfg_ready only in IDLE; lane ready follows array ready while the lane is open.
module linear_array_run_controller
  import linear_array_run_controller_pkg::*;
#(
  parameter int PE_NUMBER_I = 1,
  parameter int PE_NUMBER_J = 1,
  parameter int BATCH_SIZE  = 1,
  parameter int LEN_WIDTH   = 16,
  parameter int RUN_WIDTH   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [LEN_WIDTH-1:0]                          cfg_len,
  input  logic [RUN_WIDTH-1:0]                          cfg_runs,
  input  logic [NT(PE_NUMBER_I, PE_NUMBER_J)-1:0]       up_t_tvalid,
  output logic [NT(PE_NUMBER_I, PE_NUMBER_J)-1:0]       up_t_tready,
  output logic [NT(PE_NUMBER_I, PE_NUMBER_J)-1:0]       arr_t_tvalid,
  input  logic [NT(PE_NUMBER_I, PE_NUMBER_J)-1:0]       arr_t_tready,
  output logic [NT(PE_NUMBER_I, PE_NUMBER_J)-1:0]       arr_t_tlast,
  input  logic [NL(PE_NUMBER_J, BATCH_SIZE)-1:0]        up_l_tvalid,
  output logic [NL(PE_NUMBER_J, BATCH_SIZE)-1:0]        up_l_tready,
  output logic [NL(PE_NUMBER_J, BATCH_SIZE)-1:0]        arr_l_tvalid,
  input  logic [NL(PE_NUMBER_J, BATCH_SIZE)-1:0]        arr_l_tready,
  output logic [NL(PE_NUMBER_J, BATCH_SIZE)-1:0]        arr_l_tlast,
  input  logic [ND(PE_NUMBER_I, BATCH_SIZE)-1:0]        mon_d_tvalid,
  input  logic [ND(PE_NUMBER_I, BATCH_SIZE)-1:0]        mon_d_tready,
  input  logic [ND(PE_NUMBER_I, BATCH_SIZE)-1:0]        mon_d_tlast,
  input  logic                                          arr_err,
  input  logic                                          arr_core_rst,
  output logic                                          busy,
  output logic                                          done,
  output logic [RUN_WIDTH-1:0]                          run_idx,
  output logic                                          err_abort,
  output logic                                          err_cfg,
  output logic                                          err_overrun
);

  localparam int N_T = NT(PE_NUMBER_I, PE_NUMBER_J);
  localparam int N_L = NL(PE_NUMBER_J, BATCH_SIZE);
  localparam int N_D = ND(PE_NUMBER_I, BATCH_SIZE);
  localparam logic [RUN_WIDTH-1:0] R_ONE = RUN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [N_T+N_L-1:0]   in_done;
  logic [N_D-1:0]       out_done, d_hs, d_last;
  logic [LEN_WIDTH-1:0] len_q;
  logic [RUN_WIDTH-1:0] runs_q;
  logic                 low_seen;
  logic                 st_run, mon_act, cfg_hs, cfg_ok, abort_req;
  logic                 out_all, last_run, adv, clr;

  // Control strobes shared by the FSM and the datapath registers.
  always_comb begin
    st_run    = (state == S_RUN);
    mon_act   = (state == S_RUN) || (state == S_DRAIN);
    cfg_hs    = cfg_valid && (state == S_IDLE);
    cfg_ok    = cfg_hs && (cfg_len != '0) && (cfg_runs != '0);
    abort_req = mon_act && (arr_err || arr_core_rst);
    d_hs      = mon_d_tvalid & mon_d_tready;
    d_last    = d_hs & mon_d_tlast;
    // Includes this cycle's tlast so the last output handshake ends DRAIN immediately.
    out_all   = &(out_done | d_last);
    last_run  = (run_idx == (runs_q - R_ONE));
    adv       = (state == S_DRAIN) && !abort_req && out_all && !last_run;
    clr       = cfg_ok || adv;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    cfg_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:  if (cfg_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (abort_req)     state_nxt = S_ABORT;
        else if (&in_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_req)    state_nxt = S_ABORT;
        else if (out_all) state_nxt = last_run ? S_DONE : S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: if (!arr_core_rst && low_seen) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Configuration, run index, output-tlast tracking and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      runs_q      <= '0;
      run_idx     <= '0;
      out_done    <= '0;
      low_seen    <= 1'b0;
      err_abort   <= 1'b0;
      err_cfg     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (cfg_hs) begin
        err_abort   <= 1'b0;
        err_overrun <= 1'b0;
        err_cfg     <= !cfg_ok;
      end
      if (cfg_ok) begin
        len_q    <= cfg_len;
        runs_q   <= cfg_runs;
        run_idx  <= '0;
        out_done <= '0;
      end
      if (adv) begin
        run_idx  <= run_idx + R_ONE;
        out_done <= '0;
      end else if (mon_act) begin
        out_done <= out_done | d_last;
      end
      if (mon_act && |(d_hs & out_done)) err_overrun <= 1'b1;
      if (abort_req) begin
        err_abort <= 1'b1;
        low_seen  <= 1'b0;
      end else if (state == S_ABORT) begin
        low_seen <= !arr_core_rst;
      end
    end
  end

  for (genvar t = 0; t < N_T; t++) begin : g_top
    lane_beat_gate #(.LEN_WIDTH(LEN_WIDTH)) u_gate (
      .clk        (clk),
      .rst        (rst),
      .run        (st_run),
      .clr        (clr),
      .len        (len_q),
      .up_tvalid  (up_t_tvalid[t]),
      .up_tready  (up_t_tready[t]),
      .arr_tvalid (arr_t_tvalid[t]),
      .arr_tready (arr_t_tready[t]),
      .arr_tlast  (arr_t_tlast[t]),
      .in_done    (in_done[t])
    );
  end

  for (genvar l = 0; l < N_L; l++) begin : g_left
    lane_beat_gate #(.LEN_WIDTH(LEN_WIDTH)) u_gate (
      .clk        (clk),
      .rst        (rst),
      .run        (st_run),
      .clr        (clr),
      .len        (len_q),
      .up_tvalid  (up_l_tvalid[l]),
      .up_tready  (up_l_tready[l]),
      .arr_tvalid (arr_l_tvalid[l]),
      .arr_tready (arr_l_tready[l]),
      .arr_tlast  (arr_l_tlast[l]),
      .in_done    (in_done[N_T+l])
    );
  end

endmodule

// File: doc/linear_array_run_controller.md
# linear_array_run_controller

Run sequencer for the parallelized linear processing array. Sits between the weight/data stream sources and the array. Opens and closes the handshakes on every top (weight) and left (data) input lane, and inserts `tlast` on the final beat of each reduction. Counts partial-sum output `tlast`s per lane to detect the end of each run and repeats for a configured number of runs. Aborts cleanly when the array reports misaligned data or enters its internal reset. `tdata`, `tid`, `tdest` and `tuser` are routed outside this block; only handshake and `tlast` signals pass through it.

## Interface
- `PE_NUMBER_I`, 1, array i-axis PE count
- `PE_NUMBER_J`, 1, array j-axis PE count
- `BATCH_SIZE`, 1, batches per run
- `LEN_WIDTH`, 16, width of beat-count configuration
- `RUN_WIDTH`, 8, width of run-count configuration
- Derived widths:
  - `NT = PE_NUMBER_I*PE_NUMBER_J` (top lanes)
  - `NL = PE_NUMBER_J*BATCH_SIZE` (left lanes)
  - `ND = PE_NUMBER_I*BATCH_SIZE` (down lanes)

Ports:
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `cfg_valid` in 1 / `cfg_ready` out 1 — configuration handshake
- `cfg_len` in LEN_WIDTH — beats per lane per run
- `cfg_runs` in RUN_WIDTH — number of runs
- `up_t_tvalid` in NT / `up_t_tready` out NT — weight source side
- `arr_t_tvalid` out NT / `arr_t_tready` in NT / `arr_t_tlast` out NT — array top side
- `up_l_tvalid` in NL / `up_l_tready` out NL — data source side
- `arr_l_tvalid` out NL / `arr_l_tready` in NL / `arr_l_tlast` out NL — array left side
- `mon_d_tvalid`, `mon_d_tready`, `mon_d_tlast` in ND — observed array output handshakes
- `arr_err` in 1 — array misaligned-data error
- `arr_core_rst` in 1 — array internal reset
- `busy` out 1; `done` out 1 (pulse); `run_idx` out RUN_WIDTH
- `err_abort` out 1; `err_cfg` out 1; `err_overrun` out 1 — all sticky

## Operation
- States: IDLE, RUN, DRAIN, DONE, ABORT.
- Reset: state IDLE. `busy`, `done`, `run_idx`, all errors, all counters and all lane flags are 0. In IDLE, `cfg_ready`=1.
- IDLE:
  - On cfg handshake, all sticky errors clear.
  - `cfg_len==0` or `cfg_runs==0`: set `err_cfg`, stay IDLE.
  - Otherwise latch both values, clear counters and flags, `run_idx`=0, go to RUN.
- Lane gating (every input lane, independent beat counter):
  - `en = (state==RUN) & ~in_done[lane]`
  - `arr_tvalid = up_tvalid & en`
  - `up_tready = arr_tready & en`
  - `arr_tlast = en & (cnt==len-1)`
  - On handshake, cnt increments. On the handshake with cnt==len-1, set `in_done`.
  - `en` derives from registers only, so there is no valid→ready combinational path.
- Output monitoring, in RUN and DRAIN: a handshake with `tlast` on down lane k sets `out_done[k]`. Any handshake on a lane whose `out_done` is already set sets `err_overrun`; the run continues.
- RUN → DRAIN when all `in_done` bits are set.
- DRAIN, once all `out_done` bits are set:
  - if `run_idx==cfg_runs-1`, go to DONE;
  - else increment `run_idx`, clear all counters and flags, go to RUN.
- DONE: `done`=1 for one cycle, then IDLE.
- `arr_err` or `arr_core_rst` high in RUN/DRAIN:
  - go to ABORT and set `err_abort`;
  - all lanes close the same cycle the state register updates.
- ABORT: stay until `arr_core_rst` has been low for 2 consecutive cycles, then IDLE. `run_idx` holds its value for diagnosis.
- `busy` = state is not IDLE.

## Timing
- Cfg handshake at cycle N: RUN at N+1, first lane handshake possible at N+1.
- Last output `tlast` handshake at cycle M:
  - intermediate run: RUN at M+1, counters cleared;
  - final run: `done` at M+1, IDLE and `cfg_ready` at M+2.
- Error sampled at cycle E: lanes closed from E+1.
- `rst` mid-run: all state clears next edge; no `tlast` is emitted.
- Simultaneous final `in_done` and final `out_done`: the state passes through DRAIN for one cycle anyway.
- `cfg_valid` outside IDLE is ignored (`cfg_ready`=0).

## Structure
- Shared package holds:
  - the state encoding (3-bit localparams);
  - the lane-count derivation functions `NT`/`NL`/`ND`, shared with the array top level.
- One natural sub-module, `lane_beat_gate`. It contains one beat counter, the done flag, and the gating/`tlast` logic. It is instantiated NT+NL times.

## Test plan
- I=J=B=1, len=4, runs=1, sources always valid:
  - 4 handshakes per lane, `arr_tlast` on beat 3;
  - one `mon_d` tlast → `done` pulse 1 cycle later.
- I=2, J=2, B=2, len=3, runs=3, random per-lane backpressure: each lane exactly 9 handshakes, `run_idx` steps 0→1→2, single `done`.
- `cfg_len=0` → `err_cfg`=1, `busy` stays 0. Next valid cfg clears `err_cfg`.
- `arr_err` pulsed mid-run:
  - all `arr_tvalid`/`up_tready` = 0 from the next cycle;
  - `err_abort`=1; IDLE after `arr_core_rst` has been low 2 cycles.
- Second `mon_d` handshake on a lane after its `tlast` → `err_overrun`=1, run completes normally.
- `rst` asserted at beat 2 of len 5 → all outputs reach reset values next cycle; the subsequent cfg runs cleanly.
